// File: rtl/ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// ctrl_seq_if
// Bundle of the signals between the instruction sequencer and its
// surroundings (run/halt control, instruction memory, decoder, datapath).
//
// Modports:
//   master : the sequencer (ctrl_seq) side
//   slave  : environment side (memory / decoder / datapath / control)
//
// Signals:
//   run, halt            control level / single-cycle halt request
//   mem_rd, mem_addr     instruction read request and address
//   mem_valid, mem_data  read data valid and instruction byte
//   ir                   instruction register to the decoder
//   decode, execute      phase strobes to the decoder
//   pc_ld, pc_ld_val     jump taken and jump target
//   pc                   program counter
//   busy, fault          activity and sticky fetch-timeout status
//   instr_count          number of completed EXECUTE cycles
// ---------------------------------------------------------------------------
interface ctrl_seq_if;
   logic        run;
   logic        halt;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic        mem_valid;
   logic [7:0]  mem_data;
   logic [7:0]  ir;
   logic        decode;
   logic        execute;
   logic        pc_ld;
   logic [7:0]  pc_ld_val;
   logic [7:0]  pc;
   logic        busy;
   logic        fault;
   logic [15:0] instr_count;

   modport master (
      input  run, halt, mem_valid, mem_data, pc_ld, pc_ld_val,
      output mem_rd, mem_addr, ir, decode, execute, pc, busy, fault,
             instr_count
   );

   modport slave (
      output run, halt, mem_valid, mem_data, pc_ld, pc_ld_val,
      input  mem_rd, mem_addr, ir, decode, execute, pc, busy, fault,
             instr_count
   );
endinterface

// File: rtl/ctrl_seq.sv
// ---------------------------------------------------------------------------
// ctrl_seq
// Instruction sequencer for the s_proc_v1 core. Fetches one instruction
// byte per instruction into ir, then issues one-cycle decode and execute
// strobes and advances or reloads the program counter. A fetch that waits
// TIMEOUT cycles without mem_valid parks the sequencer in a sticky FAULT
// state that only rst leaves.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   TIMEOUT   FETCH cycles without mem_valid before faulting (1..255)
//
// Ports:
//   clk  clock, all state changes on its rising edge
//   rst  synchronous active-high reset
//   bus  ctrl_seq_if.master (control, memory, decoder and datapath signals)
// ---------------------------------------------------------------------------
module ctrl_seq #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         TIMEOUT  = 15
) (
   input  logic          clk,
   input  logic          rst,
   ctrl_seq_if.master    bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   // Value the timeout counter holds during the last FETCH cycle allowed
   // to complete without faulting.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_reg, state_next;
   logic [7:0]  pc_reg, pc_next;
   logic [7:0]  ir_reg, ir_next;
   logic [15:0] count_reg, count_next;
   logic [7:0]  tmo_reg, tmo_next;
   logic        halt_pend_reg, halt_pend_next;

   // A halt request seen this cycle blocks the next fetch just like one
   // that was latched earlier.
   logic        go;
   assign go = bus.run & ~halt_pend_reg & ~bus.halt;

   // -----------------------------------------------------------------------
   // State register (and the sequencer's datapath registers)
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         pc_reg        <= RESET_PC;
         ir_reg        <= 8'h00;
         count_reg     <= 16'h0000;
         tmo_reg       <= 8'h00;
         halt_pend_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         ir_reg        <= ir_next;
         count_reg     <= count_next;
         tmo_reg       <= tmo_next;
         halt_pend_reg <= halt_pend_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ir_next    = ir_reg;
      count_next = count_reg;
      tmo_next   = tmo_reg;

      case (state_reg)
         ST_IDLE: begin
            if (go) begin
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (bus.mem_valid) begin
               ir_next    = bus.mem_data;
               state_next = ST_DECODE;
            end else if (tmo_reg == TMO_LAST) begin
               state_next = ST_FAULT;
            end else begin
               tmo_next = tmo_reg + 8'd1;
            end
         end
         ST_DECODE: begin
            state_next = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            pc_next    = bus.pc_ld ? bus.pc_ld_val : pc_reg + 8'd1;
            count_next = count_reg + 16'd1;
            state_next = go ? ST_FETCH : ST_IDLE;
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Every fresh fetch starts its wait count from zero.
      if (state_next == ST_FETCH && state_reg != ST_FETCH) begin
         tmo_next = 8'h00;
      end

      // Halt requests accumulate until the sequencer lands in IDLE, which
      // is where they have had their effect.
      if (state_next == ST_IDLE) begin
         halt_pend_next = 1'b0;
      end else begin
         halt_pend_next = halt_pend_reg | bus.halt;
      end
   end

   // -----------------------------------------------------------------------
   // Output decode
   // -----------------------------------------------------------------------
   always_comb begin
      bus.mem_rd  = 1'b0;
      bus.decode  = 1'b0;
      bus.execute = 1'b0;
      bus.busy    = 1'b0;
      bus.fault   = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            bus.mem_rd = 1'b1;
            bus.busy   = 1'b1;
         end
         ST_DECODE: begin
            bus.decode = 1'b1;
            bus.busy   = 1'b1;
         end
         ST_EXECUTE: begin
            bus.execute = 1'b1;
            bus.busy    = 1'b1;
         end
         ST_FAULT: begin
            bus.fault = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.mem_addr    = pc_reg;
   assign bus.pc          = pc_reg;
   assign bus.ir          = ir_reg;
   assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq
// Self-checking bench for ctrl_seq. Instructions are driven one at a time
// with random fetch wait, jump, halt placement and run level; the expected
// outputs of every cycle come from an instruction-level model (pc, ir and
// instruction count updated by the architectural rules).
// ---------------------------------------------------------------------------
module tb_ctrl_seq;

   localparam logic [7:0] RST_PC = 8'h00;
   localparam int         TMO    = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ctrl_seq_if bus ();

   ctrl_seq #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  m_pc;
   logic [7:0]  m_ir;
   logic [15:0] m_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = RST_PC;
      m_ir    = 8'h00;
      m_count = 16'h0000;
   endtask

   task automatic drive_junk();
      bus.mem_valid = 1'($urandom);
      bus.mem_data  = 8'($urandom);
      bus.pc_ld     = 1'($urandom);
      bus.pc_ld_val = 8'($urandom);
   endtask

   // Sequencer is expected idle at the coming negedge (also after a reset).
   // Leaves run=1/halt=0 so that the next edge enters FETCH. With clash set,
   // one extra cycle drives run and halt together, which must stay idle.
   task automatic idle_step(input bit clash);
      @(negedge clk);
      rst = 1'b0;
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("idle_strobes", {30'd0, bus.decode, bus.execute}, 32'd0);
      check("idle_fault", 32'(bus.fault), 32'd0);
      check("idle_pc", 32'(bus.pc), 32'(m_pc));
      check("idle_ir", 32'(bus.ir), 32'(m_ir));
      check("idle_count", 32'(bus.instr_count), 32'(m_count));
      drive_junk();
      if (clash) begin
         bus.run  = 1'b1;
         bus.halt = 1'b1;
         @(negedge clk);
         check("clash_busy", 32'(bus.busy), 32'd0);
         check("clash_mem_rd", 32'(bus.mem_rd), 32'd0);
         drive_junk();
      end
      bus.run  = 1'b1;
      bus.halt = 1'b0;
   endtask

   // One instruction, starting at its first FETCH cycle.
   // halt_phase: 0 none, 1 first FETCH cycle, 2 DECODE, 3 EXECUTE.
   task automatic instr(input logic [7:0] data, input int delay, input bit jump,
                        input logic [7:0] target, input bit keep_run,
                        input int halt_phase, input bit rst_exec,
                        output bit to_fetch);
      logic [7:0] pc0;
      pc0 = m_pc;
      for (int k = 0; k <= delay; k++) begin
         @(negedge clk);
         check("fetch_mem_rd", 32'(bus.mem_rd), 32'd1);
         check("fetch_busy", 32'(bus.busy), 32'd1);
         check("fetch_addr", 32'(bus.mem_addr), 32'(m_pc));
         check("fetch_strobes", {30'd0, bus.decode, bus.execute}, 32'd0);
         check("fetch_ir_held", 32'(bus.ir), 32'(m_ir));
         check("fetch_fault", 32'(bus.fault), 32'd0);
         bus.mem_valid = (k == delay);
         bus.mem_data  = (k == delay) ? data : ~data;
         bus.halt      = (halt_phase == 1) && (k == 0);
         bus.run       = 1'($urandom);
         bus.pc_ld     = 1'($urandom);
         bus.pc_ld_val = 8'($urandom);
      end
      m_ir = data;
      @(negedge clk);
      check("decode_strobe", {30'd0, bus.decode, bus.execute}, 32'd2);
      check("decode_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("decode_ir", 32'(bus.ir), 32'(m_ir));
      check("decode_pc", 32'(bus.pc), 32'(m_pc));
      drive_junk();
      bus.halt = (halt_phase == 2);
      bus.run  = 1'($urandom);
      @(negedge clk);
      check("exec_strobe", {30'd0, bus.decode, bus.execute}, 32'd1);
      check("exec_busy", 32'(bus.busy), 32'd1);
      check("exec_pc", 32'(bus.pc), 32'(m_pc));
      check("exec_count", 32'(bus.instr_count), 32'(m_count));
      bus.mem_valid = 1'($urandom);
      bus.mem_data  = 8'($urandom);
      bus.pc_ld     = jump;
      bus.pc_ld_val = target;
      bus.run       = keep_run;
      bus.halt      = (halt_phase == 3);
      if (rst_exec) begin
         rst = 1'b1;
         model_reset();
         to_fetch = 1'b0;
         $display("instr pc=%02h ir=%02h wait=%0d reset_in_execute", pc0, data, delay);
      end else begin
         m_pc     = jump ? target : m_pc + 8'd1;
         m_count  = m_count + 16'd1;
         to_fetch = keep_run && (halt_phase == 0);
         $display("instr pc=%02h ir=%02h wait=%0d jump=%0d next_pc=%02h count=%0d halt=%0d",
                  pc0, data, delay, jump, m_pc, m_count, halt_phase);
      end
   endtask

   // From IDLE: withhold mem_valid until the fetch times out, watch FAULT
   // persist against any input, then leave it with rst.
   task automatic fault_run();
      idle_step(1'b0);
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         check("tmo_mem_rd", 32'(bus.mem_rd), 32'd1);
         check("tmo_fault", 32'(bus.fault), 32'd0);
         bus.mem_valid = 1'b0;
         bus.mem_data  = 8'($urandom);
         bus.run       = 1'($urandom);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("fault_flag", 32'(bus.fault), 32'd1);
         check("fault_mem_rd", 32'(bus.mem_rd), 32'd0);
         check("fault_busy", 32'(bus.busy), 32'd0);
         check("fault_strobes", {30'd0, bus.decode, bus.execute}, 32'd0);
         check("fault_pc", 32'(bus.pc), 32'(m_pc));
         check("fault_ir", 32'(bus.ir), 32'(m_ir));
         drive_junk();
         bus.mem_valid = 1'b1;
         bus.run       = 1'b1;
      end
      $display("fault entered after %0d fetch cycles, pc=%02h", TMO, m_pc);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      bit tf;
      bus.run = 1'b0; bus.halt = 1'b0;
      bus.mem_valid = 1'b0; bus.mem_data = 8'h00;
      bus.pc_ld = 1'b0; bus.pc_ld_val = 8'h00;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      // Reset state is observed by the first idle_step (rst still high until then).

      // Three back-to-back instructions with immediate memory data.
      idle_step(1'b0);
      instr(8'hE0, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, tf);
      instr(8'h94, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, tf);
      instr(8'h9C, 0, 1'b0, 8'h00, 1'b0, 0, 1'b0, tf);

      // Jump to 40, then sequential (pc_ld junk outside EXECUTE is ignored).
      idle_step(1'b0);
      instr(8'($urandom), 0, 1'b1, 8'h40, 1'b1, 0, 1'b0, tf);
      instr(8'($urandom), 0, 1'b0, 8'h00, 1'b0, 0, 1'b0, tf);

      // Fetch waits of 4 and TIMEOUT-1 cycles both succeed.
      idle_step(1'b0);
      instr(8'($urandom), 4, 1'b0, 8'h00, 1'b1, 0, 1'b0, tf);
      instr(8'($urandom), TMO - 1, 1'b0, 8'h00, 1'b0, 0, 1'b0, tf);

      // Halt during DECODE with run held high: completes, then idles.
      idle_step(1'b1);
      instr(8'($urandom), 1, 1'b0, 8'h00, 1'b1, 2, 1'b0, tf);

      // PC wrap FF -> 00.
      idle_step(1'b0);
      instr(8'($urandom), 0, 1'b1, 8'hFF, 1'b1, 0, 1'b0, tf);
      instr(8'($urandom), 0, 1'b0, 8'h00, 1'b0, 0, 1'b0, tf);

      // Reset in EXECUTE, then fetch timeout and reset in FAULT.
      idle_step(1'b0);
      instr(8'($urandom), 0, 1'b0, 8'h00, 1'b1, 0, 1'b1, tf);
      fault_run();

      // Randomized sessions.
      for (int s = 0; s < 40; s++) begin
         int n;
         idle_step(($urandom_range(0, 4) == 0));
         n = 0;
         do begin
            int  dly;
            int  hp;
            bit  kr;
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2);
            hp  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            kr  = (n < 6) && ($urandom_range(0, 5) != 0);
            n++;
            instr(8'($urandom), dly, 1'($urandom), 8'($urandom), kr, hp,
                  ($urandom_range(0, 40) == 0), tf);
         end while (tf);
      end

      // Final idle check, then summary.
      idle_step(1'b0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
